id_ex_stage: RTL and testbench

ID/EX pipeline register for the five-stage MIPS pipeline, with integrated load-use hazard detection. It captures decoded operands and control from ID and drives the `IE_*` signals consumed by the EX-stage ALU and the forwarding unit. On a load-use hazard it stalls PC/IF-ID and inserts a bubble. It also honours a branch flush from EX and a whole-pipe hold from MEM.

---
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Drives EX-stage operands/control and stalls IF/ID on load-use.
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ID_valid,
  input  logic [REG_W-1:0]   ID_rs,
  input  logic [REG_W-1:0]   ID_rt,
  input  logic [REG_W-1:0]   ID_rd,
  input  logic               ID_uses_rt,
  input  logic [DATA_W-1:0]  ID_rs_data,
  input  logic [DATA_W-1:0]  ID_rt_data,
  input  logic [DATA_W-1:0]  ID_imm,
  input  logic               ID_regdst,
  input  logic               ID_alusrc,
  input  logic               ID_memread,
  input  logic               ID_memwrite,
  input  logic               ID_memtoreg,
  input  logic               ID_regwrite,
  input  logic [ALUOP_W-1:0] ID_aluop,
  input  logic               flush,
  input  logic               mem_busy,
  output logic               IE_valid,
  output logic [REG_W-1:0]   IE_rs,
  output logic [REG_W-1:0]   IE_rt,
  output logic [REG_W-1:0]   IE_rd,
  output logic [DATA_W-1:0]  IE_rs_data,
  output logic [DATA_W-1:0]  IE_rt_data,
  output logic [DATA_W-1:0]  IE_imm,
  output logic               IE_regdst,
  output logic               IE_alusrc,
  output logic               IE_memread,
  output logic               IE_memwrite,
  output logic               IE_memtoreg,
  output logic               IE_regwrite,
  output logic [ALUOP_W-1:0] IE_aluop,
  output logic [REG_W-1:0]   IE_registertowrite,
  output logic               stall_IFID,
  output logic [CNT_W-1:0]   hazard_count
);

  typedef struct packed {
    logic               valid;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic               regdst;
    logic               alusrc;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               regwrite;
    logic [ALUOP_W-1:0] aluop;
  } id_ex_t;

  id_ex_t           ex_q, ex_d, id_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0] wr_reg;
  logic             hz;

  assign id_w.valid    = ID_valid;
  assign id_w.rs       = ID_rs;
  assign id_w.rt       = ID_rt;
  assign id_w.rd       = ID_rd;
  assign id_w.rs_data  = ID_rs_data;
  assign id_w.rt_data  = ID_rt_data;
  assign id_w.imm      = ID_imm;
  assign id_w.regdst   = ID_regdst;
  assign id_w.alusrc   = ID_alusrc;
  assign id_w.memread  = ID_memread;
  assign id_w.memwrite = ID_memwrite;
  assign id_w.memtoreg = ID_memtoreg;
  assign id_w.regwrite = ID_regwrite;
  assign id_w.aluop    = ID_aluop;

  assign wr_reg = ex_q.regdst ? ex_q.rd : ex_q.rt;

  // A load to $0 never produces a value worth waiting for.
  assign hz = ex_q.valid & ex_q.memread
            & (wr_reg != '0) & ID_valid
            & ((wr_reg == ID_rs)
              | (ID_uses_rt & (wr_reg == ID_rt)));

  assign stall_IFID = mem_busy | (hz & ~flush);

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    priority case (1'b1)
      mem_busy: ;
      flush:    ex_d = '0;
      hz: begin
        ex_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      default:  ex_d = id_w;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign IE_valid           = ex_q.valid;
  assign IE_rs              = ex_q.rs;
  assign IE_rt              = ex_q.rt;
  assign IE_rd              = ex_q.rd;
  assign IE_rs_data         = ex_q.rs_data;
  assign IE_rt_data         = ex_q.rt_data;
  assign IE_imm             = ex_q.imm;
  assign IE_regdst          = ex_q.regdst;
  assign IE_alusrc          = ex_q.alusrc;
  assign IE_memread         = ex_q.memread;
  assign IE_memwrite        = ex_q.memwrite;
  assign IE_memtoreg        = ex_q.memtoreg;
  assign IE_regwrite        = ex_q.regwrite;
  assign IE_aluop           = ex_q.aluop;
  assign IE_registertowrite = wr_reg;
  assign hazard_count       = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a 2-bit hazard counter.
// Immediate assertions at each check point.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int AW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ID_valid, ID_uses_rt;
  logic [RW-1:0] ID_rs, ID_rt, ID_rd;
  logic [DW-1:0] ID_rs_data, ID_rt_data, ID_imm;
  logic          ID_regdst, ID_alusrc, ID_memread;
  logic          ID_memwrite, ID_memtoreg, ID_regwrite;
  logic [AW-1:0] ID_aluop;
  logic          flush, mem_busy;
  logic          IE_valid;
  logic [RW-1:0] IE_rs, IE_rt, IE_rd;
  logic [DW-1:0] IE_rs_data, IE_rt_data, IE_imm;
  logic          IE_regdst, IE_alusrc, IE_memread;
  logic          IE_memwrite, IE_memtoreg, IE_regwrite;
  logic [AW-1:0] IE_aluop;
  logic [RW-1:0] IE_registertowrite;
  logic          stall_IFID;
  logic [CW-1:0] hazard_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .DATA_W(DW), .REG_W(RW), .ALUOP_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_rd(ID_rd), .ID_uses_rt(ID_uses_rt),
    .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data),
    .ID_imm(ID_imm), .ID_regdst(ID_regdst),
    .ID_alusrc(ID_alusrc), .ID_memread(ID_memread),
    .ID_memwrite(ID_memwrite), .ID_memtoreg(ID_memtoreg),
    .ID_regwrite(ID_regwrite), .ID_aluop(ID_aluop),
    .flush(flush), .mem_busy(mem_busy),
    .IE_valid(IE_valid), .IE_rs(IE_rs), .IE_rt(IE_rt),
    .IE_rd(IE_rd), .IE_rs_data(IE_rs_data),
    .IE_rt_data(IE_rt_data), .IE_imm(IE_imm),
    .IE_regdst(IE_regdst), .IE_alusrc(IE_alusrc),
    .IE_memread(IE_memread), .IE_memwrite(IE_memwrite),
    .IE_memtoreg(IE_memtoreg), .IE_regwrite(IE_regwrite),
    .IE_aluop(IE_aluop),
    .IE_registertowrite(IE_registertowrite),
    .stall_IFID(stall_IFID), .hazard_count(hazard_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v,
                        input logic [RW-1:0] rs,
                        input logic [RW-1:0] rt,
                        input logic [RW-1:0] rd,
                        input logic urt,
                        input logic mr,
                        input logic rdst);
    ID_valid    = v;
    ID_rs       = rs;
    ID_rt       = rt;
    ID_rd       = rd;
    ID_uses_rt  = urt;
    ID_memread  = mr;
    ID_regdst   = rdst;
    ID_memtoreg = mr;
    ID_regwrite = 1'b1;
    ID_alusrc   = mr;
    ID_memwrite = 1'b0;
    ID_aluop    = mr ? 4'd0 : 4'd2;
    ID_rs_data  = 32'h1000_0000 | 32'(rs);
    ID_rt_data  = 32'h2000_0000 | 32'(rt);
    ID_imm      = 32'hFFFF_FFF0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    mem_busy = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_valid", IE_valid, 0);
    chk("rst_cnt", hazard_count, 0);
    chk("rst_stall", stall_IFID, 0);
    mem_busy = 1'b1;
    #1;
    chk("rst_stall_busy", stall_IFID, 1);
    mem_busy = 1'b0;
    #9;
    rst_n = 1'b1;
    tick();

    // reset mid-stream
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    chk("load_valid", IE_valid, 1);
    chk("load_wr", IE_registertowrite, 3);
    chk("load_rsdata", IE_rs_data, 32'h1000_0001);
    chk("load_aluop", IE_aluop, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_valid", IE_valid, 0);
    chk("amid_rd", IE_rd, 0);
    chk("amid_rsdata", IE_rs_data, 0);
    chk("amid_aluop", IE_aluop, 0);
    chk("amid_regwrite", IE_regwrite, 0);
    chk("amid_cnt", hazard_count, 0);
    rst_n = 1'b1;
    tick();

    // load-use on rs
    do_reset();
    set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("lw8_memread", IE_memread, 1);
    chk("lw8_wr", IE_registertowrite, 8);
    set_id(1'b1, 5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1);
    #1;
    chk("rs_stall", stall_IFID, 1);
    tick();
    chk("rs_bub_valid", IE_valid, 0);
    chk("rs_bub_rt", IE_rt, 0);
    chk("rs_bub_memread", IE_memread, 0);
    chk("rs_cnt", hazard_count, 1);
    chk("rs_stall_clr", stall_IFID, 0);
    tick();
    chk("rs_add_valid", IE_valid, 1);
    chk("rs_add_rs", IE_rs, 8);
    chk("rs_add_wr", IE_registertowrite, 10);
    chk("rs_cnt_hold", hazard_count, 1);

    // rt source gating
    do_reset();
    set_id(1'b1, 5'd1, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 5'd9, 5'd11, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rt_nouse", stall_IFID, 0);
    ID_uses_rt = 1'b1;
    #1;
    chk("rt_use", stall_IFID, 1);

    // no-stall cases
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1);
    #1;
    chk("lw0_nostall", stall_IFID, 0);
    set_id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 5'd5, 5'd6, 5'd13, 1'b1, 1'b0, 1'b1);
    #1;
    chk("inv_nostall", stall_IFID, 0);
    ID_valid = 1'b1;
    #1;
    chk("val_stall", stall_IFID, 1);

    // flush with hz
    flush = 1'b1;
    #1;
    chk("fl_stall", stall_IFID, 0);
    tick();
    flush = 1'b0;
    chk("fl_valid", IE_valid, 0);
    chk("fl_memread", IE_memread, 0);
    chk("fl_rt", IE_rt, 0);
    chk("fl_cnt", hazard_count, 0);

    // mem_busy holds with pending hz
    do_reset();
    set_id(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd8, 5'd3, 5'd14, 1'b1, 1'b0, 1'b1);
    mem_busy = 1'b1;
    #1;
    chk("mb_stall0", stall_IFID, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mb_valid", IE_valid, 1);
      chk("mb_memread", IE_memread, 1);
      chk("mb_rt", IE_rt, 8);
      chk("mb_stall", stall_IFID, 1);
      chk("mb_cnt", hazard_count, 0);
    end
    mem_busy = 1'b0;
    #1;
    chk("mb_hz_pend", stall_IFID, 1);
    tick();
    chk("mb_bub_valid", IE_valid, 0);
    chk("mb_bub_cnt", hazard_count, 1);
    tick();
    chk("mb_add_valid", IE_valid, 1);
    chk("mb_add_rs", IE_rs, 8);
    chk("mb_cnt_end", hazard_count, 1);

    // counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, 5'd1, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd7, 5'd2, 5'd15, 1'b1, 1'b0, 1'b1);
      tick();
      chk("sat_cnt", hazard_count, (i < 3) ? i + 1 : 3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
